// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcode groups, canonical NOP and the decoded field bundle.
package rv32i_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;

    // addi x0,x0,0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // Decoded instruction fields; for OP, imm[6:0] carries funct7.
    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [31:0] imm;
    } fields_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I format packer; flags bundles whose immediate does not fit the format
// or whose opcode is unknown, and substitutes the canonical NOP for them.
module instr_pack
    import rv32i_pkg::*;
(
    input  fields_t     fields,
    output logic [31:0] word,
    output logic        illegal
);

    logic        fits_i;  // imm[31:11] is a sign extension
    logic        fits_b;  // imm[31:12] is a sign extension
    logic        fits_j;  // imm[31:20] is a sign extension
    logic        low_zero;
    logic [31:0] raw;
    logic        bad;

    assign fits_i   = (&fields.imm[31:11]) | ~(|fields.imm[31:11]);
    assign fits_b   = (&fields.imm[31:12]) | ~(|fields.imm[31:12]);
    assign fits_j   = (&fields.imm[31:20]) | ~(|fields.imm[31:20]);
    assign low_zero = ~(|fields.imm[11:0]);

    // Select the format by opcode group and evaluate its immediate range rule.
    always_comb begin
        raw = NOP_WORD;
        bad = 1'b0;
        unique case (fields.opcode)
            OP: begin
                raw = {fields.imm[6:0], fields.rs2, fields.rs1, fields.funct3, fields.rd,
                       fields.opcode};
            end
            OP_IMM, LOAD: begin
                raw = {fields.imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
                bad = ~fits_i;
            end
            JALR: begin
                raw = {fields.imm[11:0], fields.rs1, 3'b000, fields.rd, fields.opcode};
                bad = ~fits_i;
            end
            STORE: begin
                raw = {fields.imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                       fields.imm[4:0], fields.opcode};
                bad = ~fits_i;
            end
            BRANCH: begin
                raw = {fields.imm[12], fields.imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                       fields.imm[4:1], fields.imm[11], fields.opcode};
                bad = ~fits_b | fields.imm[0];
            end
            LUI, AUIPC: begin
                raw = {fields.imm[31:12], fields.rd, fields.opcode};
                bad = ~low_zero;
            end
            JAL: begin
                raw = {fields.imm[20], fields.imm[10:1], fields.imm[11], fields.imm[19:12],
                       fields.rd, fields.opcode};
                bad = ~fits_j | fields.imm[0];
            end
            default: begin
                bad = 1'b1;
            end
        endcase
    end

    // Illegal bundles become a NOP so the program image stays executable.
    always_comb begin
        word    = bad ? NOP_WORD : raw;
        illegal = bad;
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded field bundles and streams the words into
// consecutive instruction-memory addresses through a single-entry output register.
module instr_encoder
    import rv32i_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [31:0]       imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              err,
    output logic [7:0]        err_count,
    output logic              wrapped
);

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LastAddr = '1;

    fields_t           in_fields;
    logic [31:0]       pack_word;
    logic              pack_illegal;

    logic              full_q, full_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              illegal_q, illegal_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        err_count_q, err_count_d;
    logic              wrapped_q, wrapped_d;

    logic              accept;
    logic              done;

    assign in_fields = '{opcode: opcode, rd: rd, rs1: rs1, rs2: rs2, funct3: funct3, imm: imm};

    instr_pack u_pack (
        .fields  (in_fields),
        .word    (pack_word),
        .illegal (pack_illegal)
    );

    assign in_ready = ~full_q | mem_ready;
    assign accept   = in_valid & in_ready;
    assign done     = full_q & mem_ready;

    // Next state: output entry refill/drain, pointer advance, error and wrap bookkeeping.
    always_comb begin
        full_d      = full_q;
        wdata_d     = wdata_q;
        illegal_d   = illegal_q;
        ptr_d       = ptr_q;
        err_count_d = err_count_q;
        wrapped_d   = wrapped_q;

        if (accept) begin
            full_d    = 1'b1;
            wdata_d   = pack_word;
            illegal_d = pack_illegal;
        end else if (done) begin
            full_d = 1'b0;
        end

        // A write completing alongside start lands at the old pointer; start wins the update.
        if (start) begin
            ptr_d       = BaseAddr;
            err_count_d = 8'd0;
            wrapped_d   = 1'b0;
        end else if (done) begin
            ptr_d = ptr_q + ADDR_W'(1);
            if (ptr_q == LastAddr) begin
                wrapped_d = 1'b1;
            end
            if (illegal_q && err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    // State register; reset drops any pending word.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q      <= 1'b0;
            wdata_q     <= 32'd0;
            illegal_q   <= 1'b0;
            ptr_q       <= BaseAddr;
            err_count_q <= 8'd0;
            wrapped_q   <= 1'b0;
        end else begin
            full_q      <= full_d;
            wdata_q     <= wdata_d;
            illegal_q   <= illegal_d;
            ptr_q       <= ptr_d;
            err_count_q <= err_count_d;
            wrapped_q   <= wrapped_d;
        end
    end

    // Outputs come straight from the registered entry so they hold while stalled.
    always_comb begin
        mem_we    = full_q;
        mem_addr  = ptr_q;
        mem_wdata = wdata_q;
        err       = full_q & illegal_q;
        err_count = err_count_q;
        wrapped   = wrapped_q;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus a randomized run
// against an arithmetic reference encoder and a write-queue scoreboard.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, mem_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;

    logic        in_ready, mem_we, err, wrapped;
    logic [7:0]  mem_addr, err_count;
    logic [31:0] mem_wdata;

    logic        in_ready2, mem_we2, err2, wrapped2;
    logic [1:0]  mem_addr2;
    logic [7:0]  err_count2;
    logic [31:0] mem_wdata2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] word;
        logic        err;
    } exp_t;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .imm(imm),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .err(err), .err_count(err_count), .wrapped(wrapped)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .imm(imm),
        .mem_we(mem_we2), .mem_ready(mem_ready), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .err(err2), .err_count(err_count2), .wrapped(wrapped2)
    );

    // Reference encoder built from field positions with shifts and masks; {illegal, word}.
    function automatic bit [32:0] ref_encode(bit [6:0] op, bit [4:0] rd_v, bit [4:0] rs1_v,
                                             bit [4:0] rs2_v, bit [2:0] f3, bit [31:0] im);
        longint    s;
        bit [31:0] w, o, d, r1, r2, f;
        bit        ok;
        s  = longint'($signed(im));
        o  = 32'(op);
        d  = 32'(rd_v) << 7;
        r1 = 32'(rs1_v) << 15;
        r2 = 32'(rs2_v) << 20;
        f  = 32'(f3) << 12;
        w  = 32'h13;
        ok = 1'b0;
        if (op == 7'h33) begin
            ok = 1'b1;
            w  = ((im & 32'h7F) << 25) | r2 | r1 | f | d | o;
        end else if (op == 7'h13 || op == 7'h03 || op == 7'h67) begin
            ok = (s >= -2048) && (s <= 2047);
            w  = ((im & 32'hFFF) << 20) | r1 | ((op == 7'h67) ? 32'd0 : f) | d | o;
        end else if (op == 7'h23) begin
            ok = (s >= -2048) && (s <= 2047);
            w  = (((im >> 5) & 32'h7F) << 25) | r2 | r1 | f | ((im & 32'h1F) << 7) | o;
        end else if (op == 7'h63) begin
            ok = (s >= -4096) && (s <= 4095) && (im % 2 == 0);
            w  = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | r2 | r1 | f |
                 (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | o;
        end else if (op == 7'h37 || op == 7'h17) begin
            ok = (im % 4096 == 0);
            w  = (im & 32'hFFFF_F000) | d | o;
        end else if (op == 7'h6F) begin
            ok = (s >= -1048576) && (s <= 1048575) && (im % 2 == 0);
            w  = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21) |
                 (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | d | o;
        end
        if (!ok) w = 32'h13;
        return {!ok, w};
    endfunction

    task automatic set_bundle(input bit [6:0] op, input bit [4:0] d, input bit [4:0] s1,
                              input bit [4:0] s2, input bit [2:0] f3, input bit [31:0] im);
        opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; imm = im;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1; in_valid = 1'b0;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
        set_bundle(7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== 8'd0) begin errors++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL reset_wrapped: got %b want 0", wrapped); end
    endtask

    task automatic test_addi();
        pulse_start();
        set_bundle(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5); in_valid = 1'b1; mem_ready = 1'b1;
        @(negedge clk); in_valid = 1'b0; #1;
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL addi_we: got %b want 1", mem_we); end
        checks++; if (mem_addr !== 8'd0) begin errors++; $display("FAIL addi_addr: got %0d want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0050_0093) begin errors++; $display("FAIL addi_wdata: got %h want 00500093", mem_wdata); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL addi_err: got %b want 0", err); end
        @(negedge clk); #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL addi_drain: mem_we got %b want 0", mem_we); end
    endtask

    task automatic test_back_to_back();
        pulse_start();
        set_bundle(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8); in_valid = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        set_bundle(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
        checks++; if (mem_addr !== 8'd0 || mem_wdata !== 32'h0020_A423) begin errors++; $display("FAIL b2b_sw: got addr %0d data %h want 0 0020a423", mem_addr, mem_wdata); end
        @(negedge clk); in_valid = 1'b0; #1;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 8'd1 || mem_wdata !== 32'hFFDF_F0EF) begin errors++; $display("FAIL b2b_jal: got we %b addr %0d data %h want 1 1 ffdff0ef", mem_we, mem_addr, mem_wdata); end
        @(negedge clk); #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL b2b_drain: mem_we got %b want 0", mem_we); end
    endtask

    task automatic test_illegal();
        pulse_start();
        set_bundle(7'h7F, 5'd1, 5'd2, 5'd3, 3'd1, 32'd0); in_valid = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        set_bundle(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0800);
        #1;
        checks++; if (mem_wdata !== 32'h13 || err !== 1'b1 || err_count !== 8'd0) begin errors++; $display("FAIL illegal_op: got data %h err %b cnt %0d want 13 1 0", mem_wdata, err, err_count); end
        @(negedge clk); in_valid = 1'b0; #1;
        checks++; if (mem_wdata !== 32'h13 || err !== 1'b1 || mem_addr !== 8'd1 || err_count !== 8'd1) begin errors++; $display("FAIL illegal_imm: got data %h err %b addr %0d cnt %0d want 13 1 1 1", mem_wdata, err, mem_addr, err_count); end
        @(negedge clk); #1;
        checks++; if (err !== 1'b0 || mem_we !== 1'b0 || err_count !== 8'd2) begin errors++; $display("FAIL illegal_count: got err %b we %b cnt %0d want 0 0 2", err, mem_we, err_count); end
    endtask

    task automatic test_stall();
        pulse_start();
        set_bundle(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5); in_valid = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_bundle(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
            #1;
            checks++; if (mem_we !== 1'b1 || mem_addr !== 8'd0 || mem_wdata !== 32'h0050_0093 || in_ready !== 1'b0) begin errors++; $display("FAIL stall_hold%0d: got we %b addr %0d data %h rdy %b want 1 0 00500093 0", i, mem_we, mem_addr, mem_wdata, in_ready); end
        end
        @(negedge clk); mem_ready = 1'b1; #1;
        checks++; if (in_ready !== 1'b1 || mem_addr !== 8'd0 || mem_wdata !== 32'h0050_0093) begin errors++; $display("FAIL stall_release: got rdy %b addr %0d data %h want 1 0 00500093", in_ready, mem_addr, mem_wdata); end
        @(negedge clk); in_valid = 1'b0; #1;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 8'd1 || mem_wdata !== 32'h1234_52B7) begin errors++; $display("FAIL stall_next: got we %b addr %0d data %h want 1 1 123452b7", mem_we, mem_addr, mem_wdata); end
        @(negedge clk); #1;
        checks++; if (mem_we !== 1'b0 || mem_addr !== 8'd2) begin errors++; $display("FAIL stall_drain: got we %b addr %0d want 0 2", mem_we, mem_addr); end
    endtask

    task automatic test_wrap();
        pulse_start();
        mem_ready = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k < 5) begin
                set_bundle(7'h13, 5'(k + 1), 5'd0, 5'd0, 3'd0, 32'(k));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (k > 0) begin
                checks++; if (mem_we2 !== 1'b1 || mem_addr2 !== 2'((k - 1) % 4) || wrapped2 !== (k == 5)) begin errors++; $display("FAIL wrap_write%0d: got we %b addr %0d wrapped %b want 1 %0d %0d", k, mem_we2, mem_addr2, wrapped2, (k - 1) % 4, k == 5); end
            end
        end
        @(negedge clk); #1;
        checks++; if (wrapped2 !== 1'b1 || mem_we2 !== 1'b0 || mem_addr2 !== 2'd1) begin errors++; $display("FAIL wrap_sticky: got wrapped %b we %b addr %0d want 1 0 1", wrapped2, mem_we2, mem_addr2); end
        pulse_start();
        #1;
        checks++; if (wrapped2 !== 1'b0 || mem_addr2 !== 2'd0) begin errors++; $display("FAIL wrap_start: got wrapped %b addr %0d want 0 0", wrapped2, mem_addr2); end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        set_bundle(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0); in_valid = 1'b1; mem_ready = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        set_bundle(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5); in_valid = 1'b1; mem_ready = 1'b0;
        @(negedge clk); in_valid = 1'b0; #1;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 8'd1 || err_count !== 8'd1) begin errors++; $display("FAIL rstmid_pending: got we %b addr %0d cnt %0d want 1 1 1", mem_we, mem_addr, err_count); end
        reset = 1'b1;
        @(negedge clk); reset = 1'b0; #1;
        checks++; if (mem_we !== 1'b0 || mem_addr !== 8'd0 || err_count !== 8'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_after: got we %b addr %0d cnt %0d rdy %b want 0 0 0 1", mem_we, mem_addr, err_count, in_ready); end
        mem_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (mem_we !== 1'b0 || mem_addr !== 8'd0) begin errors++; $display("FAIL rstmid_nowrite: got we %b addr %0d want 0 0", mem_we, mem_addr); end
    endtask

    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        bit [32:0]   r;
        bit [6:0]    ops [9] = '{7'h13, 7'h37, 7'h17, 7'h33, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23};
        bit [31:0]   im;
        int          ptr_m = 0, cnt_m = 0;
        bit          wrap_m = 1'b0, done, acc;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start     = (i == 0) || ($urandom_range(0, 399) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            mem_ready = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 4))
                0, 1:    im = 32'($signed($urandom_range(0, 10000)) - 5000);
                2:       im = $urandom() & 32'hFFFF_F000;
                3:       im = 32'($signed($urandom_range(0, 4194304)) - 2097152);
                default: im = $urandom();
            endcase
            set_bundle(($urandom_range(0, 9) == 0) ? 7'($urandom()) : ops[$urandom_range(0, 8)],
                       5'($urandom()), 5'($urandom()), 5'($urandom()), 3'($urandom()), im);
            #1;
            checks++; if (mem_we !== (q.size() != 0)) begin errors++; $display("FAIL rand_we@%0d: got %b want %b", i, mem_we, q.size() != 0); end
            checks++; if (in_ready !== (q.size() == 0 || mem_ready)) begin errors++; $display("FAIL rand_ready@%0d: got %b want %b", i, in_ready, q.size() == 0 || mem_ready); end
            checks++; if (err_count !== 8'(cnt_m) || wrapped !== wrap_m) begin errors++; $display("FAIL rand_status@%0d: got cnt %0d wrapped %b want %0d %b", i, err_count, wrapped, cnt_m, wrap_m); end
            if (q.size() != 0) begin
                checks++; if (mem_addr !== 8'(ptr_m) || mem_wdata !== q[0].word || err !== q[0].err) begin errors++; $display("FAIL rand_write@%0d: got addr %0d data %h err %b want %0d %h %b", i, mem_addr, mem_wdata, err, ptr_m, q[0].word, q[0].err); end
            end
            done = (q.size() != 0) && mem_ready;
            acc  = in_valid && (q.size() == 0 || mem_ready);
            if (done) begin
                e = q.pop_front();
                if (e.err && cnt_m < 255) cnt_m++;
                if (ptr_m == 255) wrap_m = 1'b1;
                ptr_m = (ptr_m + 1) % 256;
            end
            if (start) begin
                ptr_m = 0; cnt_m = 0; wrap_m = 1'b0;
            end
            if (acc) begin
                r = ref_encode(opcode, rd, rs1, rs2, funct3, imm);
                e.word = r[31:0];
                e.err  = r[32];
                q.push_back(e);
            end
        end
        @(negedge clk); start = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_illegal();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

RV32I instruction encoder with a write port into instruction memory: the inverse of the pipeline's instruction decoder. Accepts decoded instruction fields (opcode, rd, rs1, rs2, funct3, 32-bit immediate, in the same field convention the decoder emits) over a valid/ready handshake. Packs them into a 32-bit instruction word and writes them to consecutive instruction-memory word addresses. Used by the program loader and self-test path to build programs on-chip; out-of-range immediates and illegal opcodes are replaced by NOP and reported.

## Interface
- ADDR_W, 8: instruction-memory word-address width; memory depth is 2^ADDR_W words.
- BASE_ADDR, 0: word address loaded into the write pointer on reset and on `start`.

- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  pulse: pointer := BASE_ADDR, err_count := 0, wrapped := 0.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle this cycle.
- opcode  in  7  instruction group, decoder encoding.
- rd, rs1, rs2  in  5 each  register indices.
- funct3  in  3  funct3 field.
- imm  in  32  immediate. For opcode 0110011 (R-type), imm[6:0] is funct7.
- mem_we  out  1  write request (valid) to instruction memory.
- mem_ready  in  1  memory accepts the write this cycle.
- mem_addr  out  ADDR_W  word address of the current write.
- mem_wdata  out  32  encoded instruction word.
- err  out  1  one-cycle pulse when a substituted NOP is written.
- err_count  out  8  saturating count of substituted words.
- wrapped  out  1  sticky; set when the pointer wraps past the last word.

## Operation
- Formats by opcode:
  - R (0110011): {imm[6:0],rs2,rs1,funct3,rd,op}.
  - I (0010011, 0000011, 1100111): {imm[11:0],rs1,funct3,rd,op}. For JALR, funct3 is forced to 000.
  - S (0100011): {imm[11:5],rs2,rs1,funct3,imm[4:0],op}.
  - B (1100011): {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}.
  - U (0110111, 0010111): {imm[31:12],rd,op}.
  - J (1101111): {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
- Fields not used by a format are ignored.
- Legality checks; a violation marks the bundle illegal:
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - Any other opcode is illegal.
- An illegal bundle writes 0x00000013 (addi x0,x0,0), pulses err with that write, and increments err_count (saturating at 255).
- Output register: one entry holding {mem_wdata, illegal}; mem_we = entry full.
- Write pointer: advances by 1 on each completed write (mem_we & mem_ready), modulo 2^ADDR_W. The transition from all-ones to 0 sets wrapped.
- start with a pending write:
  - The pending write completes at the old pointer.
  - The pointer is then BASE_ADDR.
  - start takes priority over the increment in the same cycle.

## Timing
- Reset values:
  - in_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, err=0, err_count=0, wrapped=0.
- Latency: a bundle accepted at edge N appears on mem_we/mem_wdata from cycle N+1.
- in_ready = !mem_we | mem_ready, which gives full throughput of one word per cycle under continuous mem_ready.
- While mem_we & !mem_ready, mem_addr, mem_wdata and err hold stable.
- err is asserted with the write and is counted once, on the handshake cycle.
- Reset mid-transfer drops the pending word; nothing is written after the reset edge.

## Structure
- The shared package `rv32i_pkg` holds:
  - Opcode constants (OP_IMM, LUI, AUIPC, OP, JAL, JALR, BRANCH, LOAD, STORE).
  - NOP_WORD = 32'h00000013.
  - The field-bundle struct typedef.
- The decoder uses the same constants.
- Sub-module `instr_pack`: purely combinational format packing plus legality flag. `instr_encoder` holds the output register, pointer and counters.

## Test plan
- addi x1,x0,5 (op 0010011, rd 1, rs1 0, f3 0, imm 5), mem_ready=1 -> one cycle later mem_we=1, mem_addr=0, mem_wdata=0x00500093, err=0.
- sw x2,8(x1) then jal x1,-4 (imm 0xFFFFFFFC), back-to-back -> words 0x0020A423 at addr 0 and 0xFFDFF0EF at addr 1 on consecutive cycles.
- opcode 1111111, then addi with imm 0x00000800 -> both write 0x00000013, err pulses twice, err_count=2.
- mem_ready low 3 cycles during a write -> mem_we/addr/wdata held, in_ready=0, pointer unchanged, single write on release.
- ADDR_W=2, five legal writes -> addresses 0,1,2,3,0; wrapped=1 after the fourth write completes; start then resets pointer to 0 and clears wrapped.
- reset asserted while mem_we=1 & mem_ready=0 -> next cycle mem_we=0, mem_addr=BASE_ADDR, err_count=0.
